// File: rtl/trap_pkg.sv
// Shared types and helpers for the multi-source trap controller.
package trap_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } trap_state_e;

  localparam logic MCAUSE_INT_BIT = 1'b1;

  function automatic int cause_width(input int cause_base, input int n_irq);
    int w;
    w = $clog2(cause_base + n_irq);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Request/redirect bundle between the pipeline, CSR file and trap controller.
interface trap_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int N_IRQ = 4
);
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] irq_en;
  logic             global_ie;
  logic [N_IRQ-1:0] clr_pending;
  logic [XLEN-1:0]  mtvec;
  logic [XLEN-1:0]  pc_de;
  logic             de_valid;
  logic             redirect;
  logic             is_mret;
  logic             trap_taken;
  logic [XLEN-1:0]  trap_pc;
  logic             epc_taken;
  logic [XLEN-1:0]  epc;
  logic             flush;
  logic [XLEN-1:0]  mcause;
  logic [N_IRQ-1:0] pending;
  logic             in_handler;

  modport master (
    output irq, irq_en, global_ie, clr_pending, mtvec, pc_de, de_valid, redirect, is_mret,
    input  trap_taken, trap_pc, epc_taken, epc, flush, mcause, pending, in_handler
  );

  modport slave (
    input  irq, irq_en, global_ie, clr_pending, mtvec, pc_de, de_valid, redirect, is_mret,
    output trap_taken, trap_pc, epc_taken, epc, flush, mcause, pending, in_handler
  );
endinterface

// File: rtl/trap_ctrl_irq_sync_edge.sv
// One interrupt source: synchroniser chain, rising-edge detect and pending latch.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  input  logic take_clr,
  output logic pending
);
  logic irq_s;
  logic irq_d_r;
  logic pend_r;
  logic rise_s;
  logic pend_nxt_s;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign irq_s = irq;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;
      // Raw request enters at bit 0 and shifts towards the MSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
          sync_r <= SYNC_STAGES'({sync_r, irq});
        end
      end
      assign irq_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // Edge sources hold a rise until cleared (a new rise beats a clear); level sources follow irq_s.
  always_comb begin
    rise_s = irq_s & ~irq_d_r;
    if (EDGE) begin
      pend_nxt_s = rise_s | (pend_r & ~(clr | take_clr));
    end else begin
      pend_nxt_s = irq_s;
    end
  end

  // Previous synchronised level and the pending bit itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_d_r <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      irq_d_r <= irq_s;
      pend_r  <= pend_nxt_s;
    end
  end

  assign pending = pend_r;
endmodule

// File: rtl/trap_ctrl.sv
// N-source interrupt controller: priority select, trap/mret redirect pulses, mepc/mcause.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          N_IRQ       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] EDGE_MASK   = 16'h0001,
  parameter int          CAUSE_BASE  = 7,
  parameter int          VECTORED    = 0
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);
  localparam int CW = cause_width(CAUSE_BASE, N_IRQ);
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int MW = XLEN - 1;
  localparam logic [XLEN-1:0]  TVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [N_IRQ-1:0] ONE_N     = N_IRQ'(1'b1);
  localparam logic [0:0]       S_IDLE    = IDLE;
  localparam logic [0:0]       S_HANDLER = HANDLER;

  logic [N_IRQ-1:0] pend_s;
  logic [N_IRQ-1:0] elig_s;
  logic [N_IRQ-1:0] win_oh_s;
  logic [N_IRQ-1:0] take_clr_s;
  logic [IW-1:0]    win_idx_s;
  logic [CW-1:0]    cause_s;
  logic [XLEN-1:0]  vec_off_s;
  logic [XLEN-1:0]  trap_pc_s;
  logic             take_s;

  logic [0:0]       state_r;
  logic             trap_taken_r;
  logic             epc_taken_r;
  logic             flush_r;
  logic [XLEN-1:0]  trap_pc_r;
  logic [XLEN-1:0]  mepc_r;
  logic [XLEN-1:0]  mcause_r;

  generate
    for (genvar i = 0; i < N_IRQ; i++) begin : g_src
      irq_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE       (EDGE_MASK[i])
      ) u_src (
        .clk     (clk),
        .rst     (rst),
        .irq     (bus.irq[i]),
        .clr     (bus.clr_pending[i]),
        .take_clr(take_clr_s[i]),
        .pending (pend_s[i])
      );
    end
  endgenerate

  // Lowest eligible index wins: isolate its bit, encode it, and form the handler address.
  always_comb begin
    elig_s    = pend_s & bus.irq_en & {N_IRQ{bus.global_ie}};
    win_oh_s  = elig_s & (~elig_s + ONE_N);
    win_idx_s = {IW{1'b0}};
    for (int i = 0; i < N_IRQ; i++) begin
      win_idx_s = win_idx_s | (win_oh_s[i] ? IW'(i) : {IW{1'b0}});
    end
    take_s     = (state_r == S_IDLE) & (|elig_s) & bus.de_valid & ~bus.redirect & ~bus.is_mret;
    take_clr_s = take_s ? win_oh_s : {N_IRQ{1'b0}};
    cause_s    = CW'(CAUSE_BASE) + CW'(win_idx_s);
    vec_off_s  = (VECTORED != 0) ? (XLEN'(cause_s) << 2'd2) : {XLEN{1'b0}};
    trap_pc_s  = (bus.mtvec & TVEC_MASK) + vec_off_s;
  end

  // Redirect pulses, trap state captured on take, and the IDLE/HANDLER sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      trap_taken_r <= 1'b0;
      epc_taken_r  <= 1'b0;
      flush_r      <= 1'b0;
      trap_pc_r    <= {XLEN{1'b0}};
      mepc_r       <= {XLEN{1'b0}};
      mcause_r     <= {XLEN{1'b0}};
    end else begin
      trap_taken_r <= take_s;
      epc_taken_r  <= bus.is_mret;
      flush_r      <= take_s | bus.is_mret;
      if (take_s) begin
        mepc_r    <= bus.pc_de;
        mcause_r  <= {MCAUSE_INT_BIT, MW'(cause_s)};
        trap_pc_r <= trap_pc_s;
      end
      case (state_r)
        S_IDLE:    state_r <= take_s ? S_HANDLER : S_IDLE;
        S_HANDLER: state_r <= bus.is_mret ? S_IDLE : S_HANDLER;
        default:   state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.trap_taken = trap_taken_r;
  assign bus.trap_pc    = trap_pc_r;
  assign bus.epc_taken  = epc_taken_r;
  assign bus.epc        = mepc_r;
  assign bus.flush      = flush_r;
  assign bus.mcause     = mcause_r;
  assign bus.pending    = pend_s;
  assign bus.in_handler = (state_r == S_HANDLER);
endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a delay-line/queue model.
module tb_trap_ctrl;
  localparam int S  = 2;
  localparam int N  = 4;
  localparam int CB = 7;
  localparam logic [N-1:0] EMASK = 4'b0001;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] irq, irq_en, clr_pending;
  logic global_ie, de_valid, redirect, is_mret;
  logic [31:0] mtvec, pc_de;

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32), .N_IRQ(N)) if0 ();
  trap_ctrl_if #(.XLEN(32), .N_IRQ(N)) if1 ();

  assign if0.irq = irq;         assign if1.irq = irq;
  assign if0.irq_en = irq_en;   assign if1.irq_en = irq_en;
  assign if0.global_ie = global_ie; assign if1.global_ie = global_ie;
  assign if0.clr_pending = clr_pending; assign if1.clr_pending = clr_pending;
  assign if0.mtvec = mtvec;     assign if1.mtvec = mtvec;
  assign if0.pc_de = pc_de;     assign if1.pc_de = pc_de;
  assign if0.de_valid = de_valid; assign if1.de_valid = de_valid;
  assign if0.redirect = redirect; assign if1.redirect = redirect;
  assign if0.is_mret = is_mret; assign if1.is_mret = is_mret;

  trap_ctrl #(.XLEN(32), .N_IRQ(N), .SYNC_STAGES(S), .EDGE_MASK(16'h0001),
              .CAUSE_BASE(CB), .VECTORED(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  trap_ctrl #(.XLEN(32), .N_IRQ(N), .SYNC_STAGES(S), .EDGE_MASK(16'h0001),
              .CAUSE_BASE(CB), .VECTORED(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // ---------------- reference model ----------------
  // hist[k] = raw irq sampled k+1 edges ago; a source "sees" its input S edges late.
  logic [N-1:0] hist [0:S];
  logic [N-1:0] m_pend, m_elig, m_nxt;
  logic m_hand, m_trap, m_epct, m_flush, m_tk;
  logic [31:0] m_epc, m_mcause, m_tpc0, m_tpc1;
  int m_w;

  always_comb begin
    m_elig = m_pend & irq_en & {N{global_ie}};
    m_w = -1;
    for (int i = N - 1; i >= 0; i--) if (m_elig[i]) m_w = i;
    m_tk = !m_hand && (m_w >= 0) && de_valid && !redirect && !is_mret;
    m_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (EMASK[i])
        m_nxt[i] = (hist[S-1][i] && !hist[S][i]) ||
                   (m_pend[i] && !clr_pending[i] && !(m_tk && m_w == i));
      else
        m_nxt[i] = hist[S-1][i];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= '0; m_hand <= 1'b0; m_trap <= 1'b0; m_epct <= 1'b0; m_flush <= 1'b0;
      m_epc <= '0; m_mcause <= '0; m_tpc0 <= '0; m_tpc1 <= '0;
      for (int k = 0; k <= S; k++) hist[k] <= '0;
    end else begin
      m_pend <= m_nxt;
      hist[0] <= irq;
      for (int k = 1; k <= S; k++) hist[k] <= hist[k-1];
      m_trap  <= m_tk;
      m_epct  <= is_mret;
      m_flush <= m_tk | is_mret;
      if (m_tk) begin
        m_epc    <= pc_de;
        m_mcause <= 32'h8000_0000 | 32'(CB + m_w);
        m_tpc0   <= mtvec & 32'hFFFF_FFFC;
        m_tpc1   <= (mtvec & 32'hFFFF_FFFC) + 32'(4 * (CB + m_w));
        m_hand   <= 1'b1;
      end else if (is_mret) begin
        m_hand <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the sampling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("trap_taken", 32'(if0.trap_taken), 32'(m_trap));
      chk("trap_taken_vec", 32'(if1.trap_taken), 32'(m_trap));
      chk("trap_pc", if0.trap_pc, m_tpc0);
      chk("trap_pc_vec", if1.trap_pc, m_tpc1);
      chk("epc_taken", 32'(if0.epc_taken), 32'(m_epct));
      chk("epc", if0.epc, m_epc);
      chk("flush", 32'(if0.flush), 32'(m_flush));
      chk("mcause", if0.mcause, m_mcause);
      chk("pending", 32'(if0.pending), 32'(m_pend));
      chk("in_handler", 32'(if0.in_handler), 32'(m_hand));
      chk("trap_epc_excl", 32'(if0.trap_taken & if0.epc_taken), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_trap(output int k);
    k = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (if0.trap_taken === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_mret();
    is_mret = 1'b1;
    @(negedge clk);
    chk("mret_epc_pulse", 32'(if0.epc_taken), 32'd1);
    is_mret = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time %0t required finish before 400000", $time);
    $fatal(1);
  end

  initial begin
    int k;
    logic seen;
    rst = 1'b1;
    irq = '0; irq_en = '0; clr_pending = '0;
    global_ie = 1'b0; de_valid = 1'b0; redirect = 1'b0; is_mret = 1'b0;
    mtvec = 32'h0; pc_de = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_trap_taken", 32'(if0.trap_taken), 32'd0);
    chk("rst_mcause", if0.mcause, 32'd0);
    chk("rst_pending", 32'(if0.pending), 32'd0);
    chk("rst_in_handler", 32'(if0.in_handler), 32'd0);

    // Edge source 0: four-cycle latency, mepc/mcause capture, pending cleared by take.
    irq_en = 4'hF; global_ie = 1'b1; de_valid = 1'b1; pc_de = 32'h100; mtvec = 32'h1000;
    irq = 4'b0001;
    wait_trap(k);
    chk("lat_src0", 32'(k), 32'd4);
    chk("mepc_src0", if0.epc, 32'h100);
    chk("mcause_src0", if0.mcause, 32'h8000_0007);
    chk("pend0_after_take", 32'(if0.pending[0]), 32'd0);
    chk("flush_src0", 32'(if0.flush), 32'd1);
    chk("tpc_base_src0", if0.trap_pc, 32'h1000);
    chk("tpc_vec_src0", if1.trap_pc, 32'h101C);
    irq = '0;
    cyc(1);
    do_mret();

    // Sources 1 and 3 together: 1 first, 3 after mret.
    pc_de = 32'h200;
    irq = 4'b1010;
    wait_trap(k);
    chk("lat_src1", 32'(k), 32'd4);
    chk("mcause_src1", if0.mcause, 32'h8000_0008);
    irq = 4'b1000;
    cyc(4);
    pc_de = 32'h300;
    do_mret();
    wait_trap(k);
    chk("lat_after_mret", 32'(k), 32'd1);
    chk("mcause_src3", if0.mcause, 32'h8000_000A);
    chk("mepc_src3", if0.epc, 32'h300);
    irq = '0;
    cyc(4);
    do_mret();

    // Vectored address from a base with low bits set.
    mtvec = 32'h203;
    irq = 4'b0100;
    wait_trap(k);
    chk("tpc_vec_src2", if1.trap_pc, 32'h224);
    chk("tpc_base_src2", if0.trap_pc, 32'h200);
    chk("mcause_src2", if0.mcause, 32'h8000_0009);
    irq = '0;
    cyc(4);
    do_mret();

    // Asynchronous reset while in the handler clears everything without a clock edge.
    irq = 4'b0001;
    wait_trap(k);
    chk("hand_before_rst", 32'(if0.in_handler), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_handler", 32'(if0.in_handler), 32'd0);
    chk("arst_trap_pc", if0.trap_pc, 32'd0);
    chk("arst_epc", if0.epc, 32'd0);
    chk("arst_mcause", if0.mcause, 32'd0);
    chk("arst_pending", 32'(if0.pending), 32'd0);
    chk("arst_flush", 32'(if0.flush), 32'd0);
    @(negedge clk);
    irq = '0;
    rst = 1'b0;

    // Redirect held two cycles delays the take by two cycles.
    global_ie = 1'b0;
    irq = 4'b0001;
    cyc(5);
    chk("pend_no_ie", 32'(if0.pending), 32'd1);
    global_ie = 1'b1; redirect = 1'b1;
    cyc(2);
    redirect = 1'b0;
    wait_trap(k);
    chk("lat_redirect", 32'(k), 32'd1);
    irq = '0;
    cyc(1);
    do_mret();

    // mret in IDLE beats a simultaneous take; trap follows one cycle after the return.
    global_ie = 1'b0;
    irq = 4'b0001;
    cyc(5);
    global_ie = 1'b1; is_mret = 1'b1;
    @(negedge clk);
    chk("mret_first_epc", 32'(if0.epc_taken), 32'd1);
    chk("mret_first_trap", 32'(if0.trap_taken), 32'd0);
    is_mret = 1'b0;
    wait_trap(k);
    chk("lat_after_idle_mret", 32'(k), 32'd1);
    irq = '0;
    cyc(1);
    do_mret();

    // Level source that drops before enable is never taken.
    global_ie = 1'b0;
    irq = 4'b0010;
    cyc(4);
    irq = '0;
    cyc(5);
    chk("level_dropped_pending", 32'(if0.pending), 32'd0);
    global_ie = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | if0.trap_taken;
    end
    chk("level_dropped_no_trap", 32'(seen), 32'd0);

    // clr_pending coincident with a new edge: the set wins; a lone clear works.
    global_ie = 1'b0;
    irq = 4'b0001;
    cyc(2);
    clr_pending = 4'b1111;
    @(negedge clk);
    clr_pending = '0;
    chk("clr_vs_set", 32'(if0.pending[0]), 32'd1);
    clr_pending = 4'b0001;
    @(negedge clk);
    clr_pending = '0;
    chk("clr_alone", 32'(if0.pending[0]), 32'd0);
    irq = '0;
    cyc(3);

    // Random traffic checked each cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      irq_en      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      global_ie   = ($urandom_range(0, 9) != 0);
      de_valid    = ($urandom_range(0, 4) != 0);
      redirect    = ($urandom_range(0, 5) == 0);
      is_mret     = m_hand ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      clr_pending = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      pc_de       = $urandom & 32'hFFFF_FFFC;
      mtvec       = $urandom;
      @(negedge clk);
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
